// File: rtl/signal_measure_core.sv
// rtl/signal_measure_core.sv - windowed amplitude/DC measurement and gated zero-crossing frequency counter
module signal_measure_core #(
  parameter int N                   = 8,
  parameter int FRE_DIV             = 2499,
  parameter int LOG_2_SAMPLE_POINTS = 5,
  parameter int GATE_SAMPLES        = 20000,
  parameter int HYST                = 4,
  parameter int F_W                 = 16,
  parameter int FREQ_SCALE          = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N-1:0]        signal_in_unsigned,
  input  logic                measure_start,
  input  logic                cont_mode,
  output logic [N-1:0]        vpp,
  output logic [N-1:0]        dc_offset,
  output logic signed [N-1:0] signal_dc_removed,
  output logic [F_W-1:0]      freq_out,
  output logic                freq_overflow,
  output logic                busy,
  output logic                result_valid
);
  localparam int L   = LOG_2_SAMPLE_POINTS;
  localparam int C_W = (FRE_DIV > 0) ? $clog2(FRE_DIV + 1) : 1;
  localparam int W_W = (L > 0) ? L : 1;
  localparam int S_W = N + L;
  localparam int G_W = $clog2(GATE_SAMPLES + 1);
  localparam int E_W = G_W;
  localparam int P_W = E_W + 32 + F_W;

  localparam logic [W_W-1:0]        W_LAST = W_W'((1 << L) - 1);
  localparam logic signed [N-1:0]   HYST_P = N'(HYST);
  localparam logic signed [N-1:0]   HYST_N = N'(-HYST);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_GATE, S_DONE} state_t;

  // Sample strobe divider
  logic [C_W-1:0] cnt;
  logic           sample_en;

  assign sample_en = (cnt == C_W'(FRE_DIV));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         cnt <= '0;
    else if (sample_en) cnt <= '0;
    else                cnt <= cnt + 1'b1;
  end

  // Window statistics; the *_nx values already include the current sample
  logic [W_W-1:0] wcnt;
  logic [N-1:0]   win_min, win_max, min_nx, max_nx;
  logic [S_W-1:0] win_sum, sum_nx;
  logic           dc_ok;

  always_comb begin
    min_nx = signal_in_unsigned;
    max_nx = signal_in_unsigned;
    sum_nx = S_W'(signal_in_unsigned);
    if (wcnt != '0) begin
      if (win_min < signal_in_unsigned) min_nx = win_min;
      if (win_max > signal_in_unsigned) max_nx = win_max;
      sum_nx = win_sum + S_W'(signal_in_unsigned);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt      <= '0;
      win_min   <= '0;
      win_max   <= '0;
      win_sum   <= '0;
      vpp       <= '0;
      dc_offset <= '0;
      dc_ok     <= 1'b0;
    end else if (sample_en) begin
      win_min <= min_nx;
      win_max <= max_nx;
      win_sum <= sum_nx;
      if (wcnt == W_LAST) begin
        wcnt      <= '0;
        vpp       <= max_nx - min_nx;
        dc_offset <= N'(sum_nx >> L);
        dc_ok     <= 1'b1;
      end else begin
        wcnt <= wcnt + 1'b1;
      end
    end
  end

  // DC removal with saturation to the signed N-bit range
  logic signed [N:0]   diff;
  logic signed [N-1:0] diff_sat;

  always_comb begin
    diff = $signed({1'b0, signal_in_unsigned}) - $signed({1'b0, dc_offset});
    if (diff[N] != diff[N-1])
      diff_sat = diff[N] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
    else
      diff_sat = diff[N-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         signal_dc_removed <= '0;
    else if (sample_en) signal_dc_removed <= diff_sat;
  end

  // Hysteretic comparator, evaluated one cycle after each new DC-removed sample
  logic cmp_en, cmp_high, above, below, rise;

  assign above = (signal_dc_removed > HYST_P);
  assign below = (signal_dc_removed < HYST_N);
  assign rise  = cmp_en && !cmp_high && above;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmp_en   <= 1'b0;
      cmp_high <= 1'b0;
    end else begin
      cmp_en <= sample_en;
      if (cmp_en) begin
        if (above)      cmp_high <= 1'b1;
        else if (below) cmp_high <= 1'b0;
      end
    end
  end

  // Measurement FSM
  state_t         state, state_nx;
  logic [G_W-1:0] gate_cnt;
  logic [E_W-1:0] edge_cnt, edge_nx;
  logic           gate_clr, gate_tick, gate_last, gate_end;

  assign gate_tick = (state == S_GATE) && cmp_en;
  assign gate_last = (gate_cnt == G_W'(GATE_SAMPLES - 1));
  assign gate_end  = gate_tick && gate_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx     = state;
    gate_clr     = 1'b0;
    busy         = 1'b1;
    result_valid = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (measure_start || cont_mode) state_nx = S_ARM;
      end
      S_ARM: begin
        if (cmp_en && dc_ok) begin
          state_nx = S_GATE;
          gate_clr = 1'b1;
        end
      end
      S_GATE: begin
        if (gate_end) state_nx = S_DONE;
      end
      S_DONE: begin
        result_valid = 1'b1;
        state_nx     = cont_mode ? S_ARM : S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    edge_nx = edge_cnt;
    if (rise && (edge_cnt != '1)) edge_nx = edge_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gate_cnt <= '0;
      edge_cnt <= '0;
    end else if (gate_clr) begin
      gate_cnt <= '0;
      edge_cnt <= '0;
    end else if (gate_tick) begin
      gate_cnt <= gate_cnt + 1'b1;
      edge_cnt <= edge_nx;
    end
  end

  // Result is captured from the count including the final tick so it is visible during DONE
  logic [P_W-1:0] prod;
  logic           prod_ovf;

  assign prod     = P_W'(edge_nx) * P_W'(FREQ_SCALE);
  assign prod_ovf = |prod[P_W-1:F_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      freq_out      <= '0;
      freq_overflow <= 1'b0;
    end else if (gate_end) begin
      freq_out      <= prod_ovf ? {F_W{1'b1}} : prod[F_W-1:0];
      freq_overflow <= prod_ovf;
    end
  end

endmodule

// File: tb/tb_signal_measure_core.sv
// tb/tb_signal_measure_core.sv - randomized scoreboard bench for signal_measure_core
module tb_signal_measure_core;
  localparam int FD  = 3;
  localparam int LG  = 3;
  localparam int GS  = 400;
  localparam int HY  = 4;
  localparam int FW  = 16;
  localparam int FWN = 4;
  localparam int WIN = 1 << LG;
  localparam int SP  = FD + 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [7:0]        sig = '0;
  logic              start = 1'b0;
  logic              cont = 1'b0;
  logic [7:0]        vpp, dc, vpp_n, dc_n;
  logic signed [7:0] sdr, sdr_n;
  logic [FW-1:0]     fq;
  logic [FWN-1:0]    fq_n;
  logic              ovf, busy, rv, ovf_n, busy_n, rv_n;

  signal_measure_core #(.N(8), .FRE_DIV(FD), .LOG_2_SAMPLE_POINTS(LG), .GATE_SAMPLES(GS),
                        .HYST(HY), .F_W(FW), .FREQ_SCALE(1)) dut (
    .clk(clk), .rst_n(rst_n), .signal_in_unsigned(sig), .measure_start(start), .cont_mode(cont),
    .vpp(vpp), .dc_offset(dc), .signal_dc_removed(sdr), .freq_out(fq), .freq_overflow(ovf),
    .busy(busy), .result_valid(rv));

  signal_measure_core #(.N(8), .FRE_DIV(FD), .LOG_2_SAMPLE_POINTS(LG), .GATE_SAMPLES(GS),
                        .HYST(HY), .F_W(FWN), .FREQ_SCALE(1)) dut_n (
    .clk(clk), .rst_n(rst_n), .signal_in_unsigned(sig), .measure_start(start), .cont_mode(cont),
    .vpp(vpp_n), .dc_offset(dc_n), .signal_dc_removed(sdr_n), .freq_out(fq_n), .freq_overflow(ovf_n),
    .busy(busy_n), .result_valid(rv_n));

  always #5 clk = ~clk;

  typedef struct { int cyc; int sd; bit win; int v; int d; } smp_t;
  typedef struct { int cyc; int f; bit o; } res_t;

  smp_t smp_q[$];
  res_t res_q[$], res_qn[$];
  int   s_a[];
  bit   st_a[], ct_a[];
  int   vectors = 0;
  int   errors = 0;
  int   cyc;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: sample-indexed, derived directly from the measurement rules
  task automatic build_model(input int ns);
    int dcv, hi, busy_end, a, e, c, mn, mx, sm, d;
    bit go;
    bit rs[];
    rs = new[ns];
    dcv = 0;
    hi  = 0;
    for (int k = 0; k < ns; k++) begin
      d = s_a[k] - dcv;
      if (d > 127)  d = 127;
      if (d < -128) d = -128;
      rs[k] = (hi == 0) && (d > HY);
      if (d > HY)       hi = 1;
      else if (d < -HY) hi = 0;
      if (k % WIN == WIN - 1) begin
        mn = 256; mx = -1; sm = 0;
        for (int i = k - WIN + 1; i <= k; i++) begin
          if (s_a[i] < mn) mn = s_a[i];
          if (s_a[i] > mx) mx = s_a[i];
          sm += s_a[i];
        end
        dcv = sm / WIN;
        smp_q.push_back('{cyc: SP*k + SP, sd: d, win: 1'b1, v: mx - mn, d: dcv});
      end else begin
        smp_q.push_back('{cyc: SP*k + SP, sd: d, win: 1'b0, v: 0, d: 0});
      end
    end
    busy_end = -1;
    for (int j = 0; j < ns; j++) begin
      if (j <= busy_end) continue;
      if (busy_end >= 0 && j == busy_end + 1) go = ct_a[j];
      else                                    go = st_a[j] || ct_a[j];
      if (go) begin
        a = (j < WIN - 1) ? WIN - 1 : j;
        e = a + GS;
        busy_end = e;
        if (e <= ns - 2) begin
          c = 0;
          for (int k = a + 1; k <= e; k++) c += int'(rs[k]);
          res_q.push_back('{cyc: SP*e + SP + 1, f: (c > 65535) ? 65535 : c, o: (c > 65535)});
          res_qn.push_back('{cyc: SP*e + SP + 1, f: (c > 15) ? 15 : c, o: (c > 15)});
        end
      end
    end
  endtask

  always @(posedge clk) begin : mon
    smp_t es;
    res_t er;
    #1;
    if (rst_n) begin
      if (smp_q.size() > 0 && smp_q[0].cyc == cyc) begin
        es = smp_q.pop_front();
        check("dc_removed", int'(sdr), es.sd);
        if (es.win) begin
          check("vpp", int'(vpp), es.v);
          check("dc_offset", int'(dc), es.d);
        end
      end
      if (rv) begin
        if (res_q.size() == 0) check("unexpected_result", 1, 0);
        else begin
          er = res_q.pop_front();
          check("result_cycle", cyc, er.cyc);
          check("freq_out", int'(fq), er.f);
          check("freq_overflow", int'(ovf), int'(er.o));
        end
      end else if (res_q.size() > 0 && res_q[0].cyc < cyc) begin
        er = res_q.pop_front();
        check("result_valid", 0, 1);
      end
      if (rv_n) begin
        if (res_qn.size() == 0) check("unexpected_result_narrow", 1, 0);
        else begin
          er = res_qn.pop_front();
          check("result_cycle_narrow", cyc, er.cyc);
          check("freq_out_narrow", int'(fq_n), er.f);
          check("freq_overflow_narrow", int'(ovf_n), int'(er.o));
        end
      end else if (res_qn.size() > 0 && res_qn[0].cyc < cyc) begin
        er = res_qn.pop_front();
        check("result_valid_narrow", 0, 1);
      end
    end
  end

  task automatic check_zero(input string tag);
    check({tag, "_vpp"}, int'(vpp), 0);
    check({tag, "_dc"}, int'(dc), 0);
    check({tag, "_sdr"}, int'(sdr), 0);
    check({tag, "_freq"}, int'(fq) + int'(fq_n), 0);
    check({tag, "_ovf"}, int'(ovf) + int'(ovf_n), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_rv"}, int'(rv) + int'(rv_n), 0);
  endtask

  task automatic alloc(input int ns);
    s_a = new[ns]; st_a = new[ns]; ct_a = new[ns];
    for (int j = 0; j < ns; j++) begin
      s_a[j] = 0; st_a[j] = 1'b0; ct_a[j] = 1'b0;
    end
  endtask

  task automatic square(input int ns, input int half, input int lo, input int hi);
    for (int j = 0; j < ns; j++) s_a[j] = ((j / half) % 2 == 1) ? hi : lo;
  endtask

  task automatic run_phase(input int ns, input bit rst_at_end);
    @(negedge clk);
    rst_n = 1'b0; sig = '0; start = 1'b0; cont = 1'b0;
    repeat (2) @(negedge clk);
    check_zero("reset");
    smp_q.delete(); res_q.delete(); res_qn.delete();
    build_model(ns);
    rst_n = 1'b1;
    for (int j = 0; j < ns; j++) begin
      sig = 8'(s_a[j]); start = st_a[j]; cont = ct_a[j];
      @(negedge clk);
      start = 1'b0;
      repeat (SP - 1) @(negedge clk);
    end
    if (rst_at_end) begin
      if (ct_a[ns-1]) check("busy_before_reset", int'(busy), 1);
      rst_n = 1'b0;
      #1;
      check_zero("mid_reset");
      repeat (2 * SP) @(negedge clk);
      check_zero("held_reset");
    end else begin
      cont = 1'b0;
      repeat (3 * SP) @(negedge clk);
      check("busy_final", int'(busy), 0);
    end
    check("pending_samples", smp_q.size(), 0);
    check("pending_results", res_q.size() + res_qn.size(), 0);
  endtask

  initial begin
    int ns, pos, half, lv;
    // single-shot square, plus an ignored start while busy
    alloc(420); square(420, 20, 50, 150);
    st_a[2] = 1'b1; st_a[100] = 1'b1;
    run_phase(420, 1'b0);
    // hysteresis: small noise around mid-scale
    alloc(430);
    for (int j = 0; j < 430; j++) s_a[j] = 128 + $urandom_range(4) - 2;
    st_a[20] = 1'b1;
    run_phase(430, 1'b0);
    // DC removal saturation in both directions
    alloc(40);
    for (int j = 0; j < 40; j++) s_a[j] = (j < 16) ? 10 : 240;
    s_a[8] = 255; s_a[24] = 0;
    run_phase(40, 1'b0);
    // continuous mode with narrow-output overflow, starts while busy, cont dropped mid-gate
    alloc(1215); square(1215, 5, 30, 220);
    for (int j = 0; j < 1000; j++) ct_a[j] = 1'b1;
    st_a[300] = 1'b1; st_a[500] = 1'b1;
    run_phase(1215, 1'b0);
    // random single-shot on random samples
    alloc(430);
    for (int j = 0; j < 430; j++) s_a[j] = $urandom_range(255);
    st_a[$urandom_range(14)] = 1'b1;
    run_phase(430, 1'b0);
    // random squares in continuous mode, reset lands mid-gate
    ns = 900 + $urandom_range(399);
    alloc(ns);
    pos = 0; lv = 0;
    while (pos < ns) begin
      half = $urandom_range(30, 2);
      for (int j = pos; j < pos + half && j < ns; j++)
        s_a[j] = (lv != 0) ? 150 + $urandom_range(105) : $urandom_range(100);
      pos += half; lv = 1 - lv;
    end
    for (int j = 0; j < ns; j++) begin
      ct_a[j] = 1'b1;
      st_a[j] = ($urandom_range(99) == 0);
    end
    run_phase(ns, 1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/signal_measure_core.md
# signal_measure_core

Parametrised amplitude and frequency measurement core for the 2023D signal-analysis path. It derives its own sample strobe from the system clock and computes a windowed DC offset and peak-to-peak value. It also produces the DC-removed signed sample and a hysteretic zero-crossing comparator, and counts rising crossings over a gated interval to report frequency. It supports single-shot and continuous measurement with a result-valid strobe, and is the generalised successor of the fixed 8-bit measurement chain.

## Interface

- N, 8: sample width (unsigned input)
- FRE_DIV, 2499: sample strobe every FRE_DIV+1 clk cycles
- LOG_2_SAMPLE_POINTS, 5: amplitude window = 2^L samples
- GATE_SAMPLES, 20000: frequency gate length in samples
- HYST, 4: comparator hysteresis, LSB
- F_W, 16: frequency output width
- FREQ_SCALE, 1: multiplier from edge count to freq_out
- clk  in  1  system clock (50 MHz)
- rst_n  in  1  asynchronous reset, active low; one clock, async active-low reset
- signal_in_unsigned  in  N  ADC sample
- measure_start  in  1  single-cycle start request
- cont_mode  in  1  1 = re-arm automatically after each result
- vpp  out  N  max−min of last complete window
- dc_offset  out  N  mean of last complete window (sum >> L)
- signal_dc_removed  out  N signed  saturated sample − dc_offset
- freq_out  out  F_W  edge_count × FREQ_SCALE, saturating
- freq_overflow  out  1  freq_out saturated in last result
- busy  out  1  FSM not IDLE
- result_valid  out  1  one-cycle pulse, new freq_out

## Operation

- Divider: cnt 0..FRE_DIV, wraps. sample_en = (cnt == FRE_DIV). Free-running from reset.
- Window: wcnt 0..2^L−1 advances on sample_en. At wcnt=0: min=max=sum=sample. Otherwise: min/max update, sum += sample (width N+L). At wcnt=2^L−1, the final sample is included, then vpp and dc_offset are latched. dc_ok is a sticky flag set at the first latch.
- DC removal: on sample_en, diff = sample − dc_offset (N+1 bits signed), saturated to [−2^(N−1), 2^(N−1)−1] and registered.
- Comparator: cmp_en = sample_en delayed 1 cycle. On cmp_en the comparator updates:
  - signal_dc_removed > +HYST → HIGH
  - signal_dc_removed < −HYST → LOW
  - otherwise it holds.
  - A LOW→HIGH change produces a one-cycle rise pulse, aligned with cmp_en.
- FSM states:
  - IDLE: go to ARM on measure_start or cont_mode.
  - ARM: go to GATE on the first cmp_en with dc_ok=1. The edge counter and gate counter clear.
  - GATE: rise pulses increment the edge counter, which saturates at all-ones. Each cmp_en increments the gate counter. The cmp_en that brings the gate counter to GATE_SAMPLES goes to DONE; a rise on that same cmp_en is counted.
  - DONE (1 cycle): latch freq_out = min(edge × FREQ_SCALE, 2^F_W−1) and set freq_overflow if clipped. Pulse result_valid. Then go to ARM if cont_mode=1, else IDLE.
- measure_start in any non-IDLE state is ignored. Deasserting cont_mode mid-gate finishes the current gate, then goes to IDLE.
- Comparator state persists across gates. A signal already HIGH at gate start does not count until it falls and rises again.
- No crossings in a gate → freq_out=0, freq_overflow=0.

## Timing

- Reset values: all outputs 0; FSM IDLE; comparator LOW; dc_ok=0; cnt, wcnt and accumulators 0.
- Reset mid-operation is immediate: all state returns to reset values and no result_valid is issued.
- The first sample_en occurs in the (FRE_DIV+1)th cycle after reset release.
- vpp and dc_offset update 1 cycle after the sample_en of window sample 2^L−1.
- signal_dc_removed updates 1 cycle after sample_en, using the dc_offset value current in the sample_en cycle.
- Comparator and rise pulse occur 1 cycle after signal_dc_removed updates.
- The DONE cycle is 1 cycle after the final gate cmp_en. freq_out changes in the same cycle that result_valid is high, and holds until the next DONE.
- Continuous mode: result period = GATE_SAMPLES+1 sample periods (one sample lost in ARM).

## Test plan

All scenarios use FRE_DIV=3, L=3, GATE_SAMPLES=400, HYST=4, N=8, F_W=16 unless stated.

- Reset:
  - Stimulus: hold rst_n=0, then release.
  - Required: all outputs 0 and busy=0; first sample_en after 4 cycles; assert rst_n mid-GATE → outputs 0, no result_valid.
- Square wave, single shot:
  - Stimulus: input alternating 50/150, period 40 samples; pulse measure_start.
  - Required: vpp=100 and dc_offset=100 once the window contains both levels; result_valid once; freq_out=10 (±1 phase); busy returns to 0.
- Hysteresis:
  - Stimulus: input constant 128 with ±3 LSB noise.
  - Required: freq_out=0, freq_overflow=0, no rise pulses.
- Saturation:
  - Stimulus: dc_offset=10 with sample=255, and dc_offset=240 with sample=0.
  - Required: signal_dc_removed=+127 and −128 respectively.
  - Stimulus: F_W=4, FREQ_SCALE=1, 40 edges per gate.
  - Required: freq_out=15, freq_overflow=1.
- Continuous mode:
  - Stimulus: cont_mode=1 with the square wave.
  - Required: result_valid every 401 samples (1604 cycles).
  - Stimulus: drop cont_mode mid-gate.
  - Required: exactly one further result, then IDLE.
  - Stimulus: measure_start pulsed while busy.
  - Required: no effect.
